// File: rtl/xmc_jtag_shifter.sv
// ---------------------------------------------------------------------------
// xmc_jtag_shifter
//
// Bit-banged JTAG shift engine for the XMC4300 debug port. A command shifts
// up to MAX_BITS bits. Each bit drives TMS/TDI while TCK is low, holds TCK
// high, and captures TDO on the last cycle of the high phase. Each TCK
// half-period lasts clk_div+1 clk_axi cycles.
//
// Optional build macro:
//   XMC_JTAG_TDO_SYNC_EN - jtag_tdo passes through a two-flop synchronizer
//                          before capture. clk_div must then be >= 2.
//
// Ports:
//   clk_axi, rst_axi_n   clock (rising edge), async active-low reset
//   jtag_en              engine enable; dropping it mid-command aborts
//   start, abort         command request (IDLE only) / cancel
//   nbits                bits per command (0 = empty, >MAX_BITS clamps)
//   clk_div              TCK half-period minus one, in clk_axi cycles
//   tms_vec, tdi_vec     per-bit TMS/TDI values, LSB first
//   tdo_vec              captured TDO bits, LSB first
//   busy, done           command active / one-cycle completion pulse
//   jtag_tck/tms/tdi     pin drivers; jtag_tdo pin input
// ---------------------------------------------------------------------------
module xmc_jtag_shifter #(
  parameter int MAX_BITS = 32
) (
  input  logic                clk_axi,
  input  logic                rst_axi_n,
  input  logic                jtag_en,
  input  logic                start,
  input  logic                abort,
  input  logic [5:0]          nbits,
  input  logic [7:0]          clk_div,
  input  logic [MAX_BITS-1:0] tms_vec,
  input  logic [MAX_BITS-1:0] tdi_vec,
  output logic [MAX_BITS-1:0] tdo_vec,
  output logic                busy,
  output logic                done,
  output logic                jtag_tck,
  output logic                jtag_tms,
  output logic                jtag_tdi,
  input  logic                jtag_tdo
);

  localparam int CNT_W = $clog2(MAX_BITS + 1);
  localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BITS);

  typedef enum logic [1:0] {IDLE, TCK_LO, TCK_HI, FINISH} state_t;

  state_t              state, state_nxt;
  logic [7:0]          div_q;
  logic [7:0]          hcnt;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_sel;
  logic [MAX_BITS-1:0] tms_q;
  logic [MAX_BITS-1:0] tdi_q;
  logic                tdo_cap;
  logic                accept;
  logic                kill;
  logic                half_end;
  logic                last_bit;

  // Saturate the requested bit count to the vector width.
  function automatic logic [CNT_W-1:0] clamp_nbits(input logic [5:0] n);
    if (int'(n) > MAX_BITS) return MAX_CNT;
    return CNT_W'(n);
  endfunction

  assign accept   = (state == IDLE) && start && jtag_en && !abort;
  assign kill     = abort || !jtag_en;
  // The counter compares before incrementing, so clk_div=255 gives 256 cycles.
  assign half_end = (hcnt == div_q);
  assign last_bit = ((idx + CNT_W'(1)) >= cnt_q);
  assign idx_sel  = idx[IDX_W-1:0];

`ifdef XMC_JTAG_TDO_SYNC_EN
  logic tdo_s1, tdo_s2;

  always_ff @(posedge clk_axi or negedge rst_axi_n) begin
    if (!rst_axi_n) begin
      tdo_s1 <= 1'b0;
      tdo_s2 <= 1'b0;
    end else begin
      tdo_s1 <= jtag_tdo;
      tdo_s2 <= tdo_s1;
    end
  end

  assign tdo_cap = tdo_s2;
`else
  assign tdo_cap = jtag_tdo;
`endif

  // State register
  always_ff @(posedge clk_axi or negedge rst_axi_n) begin
    if (!rst_axi_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (clamp_nbits(nbits) == '0) ? FINISH : TCK_LO;
      end
      TCK_LO: begin
        if (kill)          state_nxt = IDLE;
        else if (half_end) state_nxt = TCK_HI;
      end
      TCK_HI: begin
        if (kill)          state_nxt = IDLE;
        else if (half_end) state_nxt = last_bit ? FINISH : TCK_LO;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, command latch and TDO capture
  always_ff @(posedge clk_axi or negedge rst_axi_n) begin
    if (!rst_axi_n) begin
      hcnt    <= 8'd0;
      idx     <= '0;
      cnt_q   <= '0;
      div_q   <= 8'd0;
      tdo_vec <= '0;
    end else if (accept) begin
      hcnt    <= 8'd0;
      idx     <= '0;
      cnt_q   <= clamp_nbits(nbits);
      div_q   <= clk_div;
      tdo_vec <= '0;
    end else begin
      // The half-period counter restarts on every phase change.
      if ((state == TCK_LO || state == TCK_HI) && state_nxt == state)
        hcnt <= hcnt + 8'd1;
      else
        hcnt <= 8'd0;

      if (state == TCK_HI && half_end && !kill) begin
        tdo_vec[idx_sel] <= tdo_cap;
        if (!last_bit) idx <= idx + CNT_W'(1);
      end

      if (state_nxt == IDLE) idx <= '0;
    end
  end

  // The per-bit vectors are only observed while a command is active.
  always_ff @(posedge clk_axi) begin
    if (accept) begin
      tms_q <= tms_vec;
      tdi_q <= tdi_vec;
    end
  end

  // Output decode
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    jtag_tck = 1'b0;
    jtag_tms = 1'b1;
    jtag_tdi = 1'b0;
    case (state)
      TCK_LO: begin
        busy     = 1'b1;
        jtag_tms = tms_q[idx_sel];
        jtag_tdi = tdi_q[idx_sel];
      end
      TCK_HI: begin
        busy     = 1'b1;
        jtag_tck = 1'b1;
        jtag_tms = tms_q[idx_sel];
        jtag_tdi = tdi_q[idx_sel];
      end
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_xmc_jtag_shifter.sv
// ---------------------------------------------------------------------------
// tb_xmc_jtag_shifter
//
// Directed testbench for xmc_jtag_shifter. It covers bit timing, loopback
// capture, empty and clamped counts, the slowest divider, abort, enable drop,
// ignored starts and reset during a command. The loopback cases hold in both
// builds of the synchronizer option.
// ---------------------------------------------------------------------------
module tb_xmc_jtag_shifter;

  logic        clk_axi   = 1'b0;
  logic        rst_axi_n = 1'b0;
  logic        jtag_en   = 1'b0;
  logic        start     = 1'b0;
  logic        abort     = 1'b0;
  logic [5:0]  nbits     = 6'd0;
  logic [7:0]  clk_div   = 8'd0;
  logic [31:0] tms_vec   = 32'd0;
  logic [31:0] tdi_vec   = 32'd0;
  logic [31:0] tdo_vec;
  logic        busy, done, jtag_tck, jtag_tms, jtag_tdi;
  logic        jtag_tdo;
  logic        loopback  = 1'b0;

  assign jtag_tdo = loopback ? jtag_tdi : 1'b0;

  int checks   = 0;
  int failures = 0;

  int          r_cycles, r_pulses, r_hi_min, r_hi_max, r_lo_busy, r_tms_low;
  logic        r_busy_first, r_end_ok, r_done_after;
  logic [31:0] r_tdo;
  int          w_done, w_busy;

  xmc_jtag_shifter #(.MAX_BITS(32)) dut (
    .clk_axi   (clk_axi),
    .rst_axi_n (rst_axi_n),
    .jtag_en   (jtag_en),
    .start     (start),
    .abort     (abort),
    .nbits     (nbits),
    .clk_div   (clk_div),
    .tms_vec   (tms_vec),
    .tdi_vec   (tdi_vec),
    .tdo_vec   (tdo_vec),
    .busy      (busy),
    .done      (done),
    .jtag_tck  (jtag_tck),
    .jtag_tms  (jtag_tms),
    .jtag_tdi  (jtag_tdi),
    .jtag_tdo  (jtag_tdo)
  );

  always #5 clk_axi = ~clk_axi;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_axi);
    #1;
  endtask

  // Present a start pulse. Return #1 after the edge that samples it.
  task automatic start_cmd(input logic [5:0] nb, input logic [7:0] dv,
                           input logic [31:0] tms, input logic [31:0] tdi);
    @(negedge clk_axi);
    nbits   = nb;
    clk_div = dv;
    tms_vec = tms;
    tdi_vec = tdi;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Run one command and measure TCK timing until done. The poke_at argument
  // re-asserts start, with different operands, at that cycle.
  task automatic run_cmd(input logic [5:0] nb, input logic [7:0] dv,
                         input logic [31:0] tms, input logic [31:0] tdi,
                         input int poke_at);
    int   n;
    int   run;
    logic prev;
    start_cmd(nb, dv, tms, tdi);
    n = 0; run = 0; prev = 1'b0;
    r_pulses = 0; r_hi_min = 1000000; r_hi_max = 0; r_lo_busy = 0; r_tms_low = 0;
    r_busy_first = busy;
    while (!done && n < 20000) begin
      if (n == poke_at) begin
        start = 1'b1; nbits = 6'd1; tms_vec = '1; tdi_vec = '1;
      end else begin
        start = 1'b0;
      end
      if (jtag_tck) begin
        if (!prev) r_pulses++;
        run++;
      end else begin
        if (prev) begin
          if (run < r_hi_min) r_hi_min = run;
          if (run > r_hi_max) r_hi_max = run;
          run = 0;
        end
        if (busy) r_lo_busy++;
      end
      if (busy && !jtag_tms) r_tms_low++;
      prev = jtag_tck;
      tick();
      n++;
    end
    start = 1'b0;
    if (prev) begin
      if (run < r_hi_min) r_hi_min = run;
      if (run > r_hi_max) r_hi_max = run;
    end
    r_cycles = n + 1;
    r_end_ok = done && !busy && !jtag_tck && jtag_tms && !jtag_tdi;
    r_tdo    = tdo_vec;
    tick();
    r_done_after = done;
  endtask

  // Count done and busy cycles over a quiet window.
  task automatic watch(input int cyc);
    w_done = 0; w_busy = 0;
    for (int i = 0; i < cyc; i++) begin
      tick();
      if (done) w_done++;
      if (busy) w_busy++;
    end
  endtask

  initial begin
    // Reset values while reset is held
    #2;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_pins", {jtag_tck, jtag_tms, jtag_tdi}, 3'b010);
    check_val("rst_tdo", tdo_vec, 0);
    repeat (3) @(negedge clk_axi);
    rst_axi_n = 1'b1;
    jtag_en   = 1'b1;
    tick();

    // 5 bits, divider 1, TMS all ones
    run_cmd(6'd5, 8'd1, 32'h1F, 32'h0, -1);
    check_val("a_cycles", r_cycles, 21);
    check_val("a_pulses", r_pulses, 5);
    check_val("a_hi_min", r_hi_min, 2);
    check_val("a_hi_max", r_hi_max, 2);
    check_val("a_lo_busy", r_lo_busy, 10);
    check_val("a_tms_low", r_tms_low, 0);
    check_val("a_busy_first", r_busy_first, 1);
    check_val("a_finish_pins", r_end_ok, 1);
    check_val("a_done_1cyc", r_done_after, 0);

    // 32-bit loopback capture
    loopback = 1'b1;
    run_cmd(6'd32, 8'd3, 32'h0, 32'hA5A5_0F0F, -1);
    loopback = 1'b0;
    check_val("b_tdo", r_tdo, 32'hA5A5_0F0F);
    check_val("b_cycles", r_cycles, 257);
    check_val("b_pulses", r_pulses, 32);

    // Empty command: done right after accept, no TCK, tdo cleared
    run_cmd(6'd0, 8'd2, 32'h0, 32'hFFFF_FFFF, -1);
    check_val("c_cycles", r_cycles, 1);
    check_val("c_pulses", r_pulses, 0);
    check_val("c_busy_first", r_busy_first, 0);
    check_val("c_tdo_clear", r_tdo, 0);

    // Over-long count clamps to 32 bits
    run_cmd(6'd40, 8'd0, 32'h0, 32'h0, -1);
    check_val("d_pulses", r_pulses, 32);
    check_val("d_cycles", r_cycles, 65);
    check_val("d_hi_max", r_hi_max, 1);

    // Slowest divider: 256-cycle half periods
    run_cmd(6'd1, 8'd255, 32'h1, 32'h0, -1);
    check_val("e_cycles", r_cycles, 513);
    check_val("e_hi_min", r_hi_min, 256);

    // Start repeated while busy is ignored
    run_cmd(6'd4, 8'd1, 32'h0, 32'hF, 5);
    check_val("f_cycles", r_cycles, 17);
    check_val("f_pulses", r_pulses, 4);
    check_val("f_tms_low", r_tms_low, 16);

    // Start with jtag_en low is ignored
    jtag_en = 1'b0;
    start_cmd(6'd3, 8'd0, 32'h0, 32'h7);
    check_val("g_busy", busy, 0);
    check_val("g_pins", {jtag_tck, jtag_tms, jtag_tdi}, 3'b010);
    watch(10);
    check_val("g_no_done", w_done, 0);
    check_val("g_no_busy", w_busy, 0);
    jtag_en = 1'b1;

    // Abort and start together in IDLE: abort wins
    abort = 1'b1;
    start_cmd(6'd3, 8'd0, 32'h0, 32'h7);
    abort = 1'b0;
    check_val("h_busy", busy, 0);
    watch(10);
    check_val("h_no_done", w_done + w_busy, 0);

    // Abort during bit 3 of an 8-bit command
    loopback = 1'b1;
    start_cmd(6'd8, 8'd1, 32'hFF, 32'hB5);
    repeat (13) tick();
    check_val("i_busy_bit3", busy, 1);
    check_val("i_tdi_bit3", jtag_tdi, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("i_busy", busy, 0);
    check_val("i_pins", {jtag_tck, jtag_tms, jtag_tdi}, 3'b010);
    check_val("i_tdo_partial", tdo_vec, 32'h5);
    watch(20);
    check_val("i_no_done", w_done, 0);
    loopback = 1'b0;

    // jtag_en falling mid-command behaves as abort
    start_cmd(6'd8, 8'd1, 32'h0, 32'h0);
    repeat (5) tick();
    jtag_en = 1'b0;
    tick();
    check_val("j_busy", busy, 0);
    check_val("j_tck", jtag_tck, 0);
    jtag_en = 1'b1;
    watch(20);
    check_val("j_no_done", w_done, 0);

    // Reset pulsed low mid-command
    loopback = 1'b1;
    start_cmd(6'd8, 8'd1, 32'hFF, 32'hFF);
    repeat (10) tick();
    check_val("k_tdo_pre", tdo_vec, 32'h3);
    #2 rst_axi_n = 1'b0;
    #1;
    check_val("k_busy", busy, 0);
    check_val("k_done", done, 0);
    check_val("k_pins", {jtag_tck, jtag_tms, jtag_tdi}, 3'b010);
    check_val("k_tdo", tdo_vec, 0);
    @(negedge clk_axi);
    rst_axi_n = 1'b1;
    watch(40);
    check_val("k_no_done", w_done, 0);
    check_val("k_no_busy", w_busy, 0);
    loopback = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
